column_pattern_gen: RTL and testbench
=====================================

Name: column_pattern_gen

Overview:
- Parametrised successor to the fixed 16-row column pattern source.
- Generates an endless stream of obstacle columns for the scrolling LED playfield: blank spacing columns, then pipe columns with a pseudo-random gap.
- Each column is handed to the playfield shifter over a valid/ready handshake.
- Sits between the game controller (restart, freeze) and the matrix shift register.

Parameters:
ROWS, 16, rows per column; power of 2, >= 8
GAP, 4, open rows in a pipe; 2 <= GAP <= ROWS-2
PIPE_W, 2, consecutive columns per pipe; >= 1
SPACING, 4, blank columns between pipes; >= 1
SEED, 8'hA5, LFSR reload value; 0 is forced to 8'h01

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
restart  input  1  synchronous reload of FSM and LFSR, active-high
freeze  input  1  holds all state; col_valid forced 0 while high
col_ready  input  1  consumer accepts the current column
col_valid  output  1  output_data holds a valid column
output_data  output  ROWS x 1 (unpacked [0:ROWS-1])  1 = wall cell; index 0 = top row
is_pipe  output  1  current column is a pipe column
gap_top  output  $clog2(ROWS)  first open row of the current or most recent pipe

Behaviour:
- Reset (reset=0, async):
  - state=PRIME, lfsr=SEED, col_cnt=0.
  - col_valid=0, output_data all 0, is_pipe=0, gap_top=0.
- FSM states: PRIME, SPACE, PIPE.
- PRIME: lasts exactly one clock after reset release, then goes to SPACE with col_cnt=0 and col_valid=1. The first column is therefore valid on the 2nd rising edge after reset rises.
- fire = col_valid & col_ready & ~freeze.
- All state, LFSR and col_cnt advance only on fire. The next column appears on the clock edge that accepts the current one: zero bubble, continuous stream.
- SPACE:
  - output_data all 0, is_pipe=0.
  - On fire with col_cnt<SPACING-1: col_cnt++.
  - On fire with col_cnt==SPACING-1: go to PIPE, col_cnt=0, and gap_top <= clamp(lfsr[K-1:0]), K=$clog2(ROWS), using the pre-step LFSR value.
- PIPE:
  - output_data[i] = 0 for gap_top <= i <= gap_top+GAP-1, else 1; is_pipe=1.
  - On fire with col_cnt==PIPE_W-1: go to SPACE, col_cnt=0. Otherwise col_cnt++.
  - gap_top is constant across all PIPE_W columns of one pipe.
- clamp(r): MIN_TOP=1, MAX_TOP=ROWS-GAP-1. r<MIN_TOP gives MIN_TOP; r>MAX_TOP gives MAX_TOP; otherwise r. At least one wall cell is always present above and below the gap.
- LFSR: 8-bit Fibonacci, fb = l[7]^l[5]^l[4]^l[3], next = {l[6:0], fb}. Steps once per fire. The all-zero state is unreachable.
- freeze=1:
  - col_valid=0; state, LFSR and outputs are held.
  - col_ready is ignored.
  - On freeze release, col_valid=1 in the same cycle with the same column.
- restart=1 (synchronous, priority over fire and freeze): next edge gives state=PRIME, lfsr=SEED, col_cnt=0, col_valid=0. It behaves as a reset, but synchronous.
- reset asserted mid-stream clears everything immediately, with no wait for a clock edge.
- col_ready while col_valid=0 has no effect.
- All outputs are registered; no combinational path from col_ready to any output.

Optional Feature:
- Macro: COLPAT_DIFFICULTY_EN.
- With it defined:
  - A 4-bit pipe counter increments on each PIPE->SPACE transition and saturates at 15.
  - Effective gap = max(2, GAP - (pipe_cnt>>2)); MAX_TOP is recomputed from the effective gap.
  - Added output difficulty [1:0] = pipe_cnt[3:2].
  - The counter clears on reset and on restart.
- Without it: the gap is fixed at GAP and the difficulty port is absent.

Test Plan:
All scenarios use the default parameters.
1. Release reset, col_ready=1 held -> col_valid=0 on 1st edge, 1 from 2nd edge. First 4 columns are all 0 with is_pipe=0. LFSR sequence A5,4A,95,2A,54.
2. Continue from 1 -> next 2 columns: is_pipe=1, gap_top=10, output_data bits 15..0 = 16'hC3FF. Then 4 blank columns follow.
3. col_ready=0 for 5 cycles mid-PIPE -> output_data, gap_top and LFSR are all unchanged. On col_ready=1, the stream resumes at the same column.
4. freeze=1 for 3 cycles with col_ready=1 -> col_valid=0 and no state advance. Release -> the identical column is shown with col_valid=1.
5. restart pulse during PIPE -> next edge col_valid=0, then the stream repeats scenario 1 exactly. Async reset low between edges clears outputs immediately.
6. Force gap_top clamp with SEED=8'h00 -> LFSR starts at 01, and every gap_top stays within 1..11 over 64 pipes. With COLPAT_DIFFICULTY_EN: after 8 pipes the gap is 2, and difficulty saturates at 3.

Source files
------------

// File: rtl/column_pattern_gen.sv
// rtl/column_pattern_gen.sv - obstacle column pattern source for the scrolling LED playfield
//
// Emits an endless stream of columns: SPACING blank columns, then PIPE_W
// pipe columns sharing one pseudo-random gap, handed out over valid/ready.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   restart      synchronous reload of FSM and LFSR (active-high, beats freeze)
//   freeze       holds all state; col_valid forced low while high
//   col_ready    consumer accepts the current column
//   col_valid    output_data holds a valid column
//   output_data  ROWS cells, 1 = wall, index 0 = top row
//   is_pipe      current column is a pipe column
//   gap_top      first open row of the current or most recent pipe
//   difficulty   pipe_cnt[3:2] (only with COLPAT_DIFFICULTY_EN)
//
// Optional feature macro: COLPAT_DIFFICULTY_EN (shrinking gap, difficulty port).
module column_pattern_gen #(
  parameter int          ROWS    = 16,
  parameter int          GAP     = 4,
  parameter int          PIPE_W  = 2,
  parameter int          SPACING = 4,
  parameter logic [7:0]  SEED    = 8'hA5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    restart,
  input  logic                    freeze,
  input  logic                    col_ready,
  output logic                    col_valid,
  output logic                    output_data [0:ROWS-1],
  output logic                    is_pipe,
  output logic [$clog2(ROWS)-1:0] gap_top
`ifdef COLPAT_DIFFICULTY_EN
  ,
  output logic [1:0]              difficulty
`endif
);

  localparam int         K        = $clog2(ROWS);
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [K:0] GAP_W    = (K+1)'(GAP);
  localparam logic [K:0] ROWS_W   = (K+1)'(ROWS);

  typedef enum logic [1:0] {PRIME, SPACE, PIPE} state_t;

  state_t          r_state, w_state_n;
  logic            r_armed, w_armed_n;
  logic            r_valid, w_valid_n;
  logic [7:0]      r_lfsr, w_lfsr_n, w_lfsr_step;
  logic [15:0]     r_cnt, w_cnt_n;
  logic [K-1:0]    r_gap_top, w_gap_n;
  logic [ROWS-1:0] r_data, w_data_n;
  logic            r_is_pipe;
  logic            w_fire;
  logic [K:0]      w_gap_eff, w_max_top, w_raw, w_clamp;

`ifdef COLPAT_DIFFICULTY_EN
  logic [3:0]      r_pipe_cnt, w_pipe_cnt_n;
  logic [K:0]      w_dec;

  // Gap narrows by one every four pipes, never below two rows.
  assign w_dec     = (K+1)'(r_pipe_cnt[3:2]);
  assign w_gap_eff = (GAP_W < w_dec + (K+1)'(2)) ? (K+1)'(2) : GAP_W - w_dec;
  assign difficulty = r_pipe_cnt[3:2];
`else
  assign w_gap_eff = GAP_W;
`endif

  assign w_fire      = r_valid & col_ready & ~freeze;
  assign w_lfsr_step = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  // Keep at least one wall cell above and below the gap.
  assign w_max_top = ROWS_W - w_gap_eff - (K+1)'(1);
  assign w_raw     = {1'b0, r_lfsr[K-1:0]};
  assign w_clamp   = (w_raw < (K+1)'(1)) ? (K+1)'(1) :
                     (w_raw > w_max_top) ? w_max_top : w_raw;

  always_comb begin
    w_state_n = r_state;
    w_armed_n = r_armed;
    w_valid_n = r_valid;
    w_lfsr_n  = r_lfsr;
    w_cnt_n   = r_cnt;
    w_gap_n   = r_gap_top;
`ifdef COLPAT_DIFFICULTY_EN
    w_pipe_cnt_n = r_pipe_cnt;
`endif
    case (r_state)
      // First edge after reset/restart only arms; the second opens the stream.
      PRIME: begin
        if (!freeze) begin
          if (!r_armed) begin
            w_armed_n = 1'b1;
          end else begin
            w_state_n = SPACE;
            w_cnt_n   = '0;
            w_valid_n = 1'b1;
          end
        end
      end
      SPACE: begin
        if (w_fire) begin
          w_lfsr_n = w_lfsr_step;
          if (r_cnt == 16'(SPACING-1)) begin
            w_state_n = PIPE;
            w_cnt_n   = '0;
            w_gap_n   = w_clamp[K-1:0];
          end else begin
            w_cnt_n = r_cnt + 16'd1;
          end
        end
      end
      PIPE: begin
        if (w_fire) begin
          w_lfsr_n = w_lfsr_step;
          if (r_cnt == 16'(PIPE_W-1)) begin
            w_state_n = SPACE;
            w_cnt_n   = '0;
`ifdef COLPAT_DIFFICULTY_EN
            if (r_pipe_cnt != 4'hF) w_pipe_cnt_n = r_pipe_cnt + 4'd1;
`endif
          end else begin
            w_cnt_n = r_cnt + 16'd1;
          end
        end
      end
      default: w_state_n = PRIME;
    endcase
  end

  // Column image for the next state; pipe effective gap is stable for a whole pipe.
  always_comb begin
    w_data_n = '0;
    for (int i = 0; i < ROWS; i++) begin
      w_data_n[i] = (w_state_n == PIPE) &&
                    !(((K+1)'(i) >= {1'b0, w_gap_n}) &&
                      ((K+1)'(i) <  {1'b0, w_gap_n} + w_gap_eff));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= PRIME;
      r_armed   <= 1'b0;
      r_valid   <= 1'b0;
      r_lfsr    <= SEED_EFF;
      r_cnt     <= '0;
      r_gap_top <= '0;
      r_data    <= '0;
      r_is_pipe <= 1'b0;
`ifdef COLPAT_DIFFICULTY_EN
      r_pipe_cnt <= '0;
`endif
    end else if (restart) begin
      r_state   <= PRIME;
      r_armed   <= 1'b0;
      r_valid   <= 1'b0;
      r_lfsr    <= SEED_EFF;
      r_cnt     <= '0;
      r_gap_top <= '0;
      r_data    <= '0;
      r_is_pipe <= 1'b0;
`ifdef COLPAT_DIFFICULTY_EN
      r_pipe_cnt <= '0;
`endif
    end else begin
      r_state   <= w_state_n;
      r_armed   <= w_armed_n;
      r_valid   <= w_valid_n;
      r_lfsr    <= w_lfsr_n;
      r_cnt     <= w_cnt_n;
      r_gap_top <= w_gap_n;
      r_data    <= w_data_n;
      r_is_pipe <= (w_state_n == PIPE);
`ifdef COLPAT_DIFFICULTY_EN
      r_pipe_cnt <= w_pipe_cnt_n;
`endif
    end
  end

  // freeze gates valid directly so release shows the held column in the same cycle.
  assign col_valid = r_valid & ~freeze;
  assign is_pipe   = r_is_pipe;
  assign gap_top   = r_gap_top;

  always_comb begin
    for (int i = 0; i < ROWS; i++) output_data[i] = r_data[i];
  end

endmodule

// File: tb/tb_column_pattern_gen.sv
// tb/tb_column_pattern_gen.sv - self-checking bench for column_pattern_gen
module tb_column_pattern_gen;

  localparam int ROWS    = 16;
  localparam int GAP     = 4;
  localparam int PIPE_W  = 2;
  localparam int SPACING = 4;
  localparam int PERIOD  = SPACING + PIPE_W;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       restart = 1'b0;
  logic       freeze = 1'b0;
  logic       col_ready = 1'b0;
  logic       col_valid;
  logic       output_data [0:ROWS-1];
  logic       is_pipe;
  logic [3:0] gap_top;

  logic       reset2 = 1'b0;
  logic       one = 1'b1;
  logic       zero = 1'b0;
  logic       valid2;
  logic       data2 [0:ROWS-1];
  logic       pipe2;
  logic [3:0] gap2;
`ifdef COLPAT_DIFFICULTY_EN
  logic [1:0] difficulty;
  logic [1:0] diff2;
`endif

  column_pattern_gen dut (
    .clk(clk), .reset(reset), .restart(restart), .freeze(freeze),
    .col_ready(col_ready), .col_valid(col_valid), .output_data(output_data),
    .is_pipe(is_pipe), .gap_top(gap_top)
`ifdef COLPAT_DIFFICULTY_EN
    , .difficulty(difficulty)
`endif
  );

  column_pattern_gen #(.SEED(8'h00)) dut_seed0 (
    .clk(clk), .reset(reset2), .restart(zero), .freeze(zero),
    .col_ready(one), .col_valid(valid2), .output_data(data2),
    .is_pipe(pipe2), .gap_top(gap2)
`ifdef COLPAT_DIFFICULTY_EN
    , .difficulty(diff2)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] pack(input logic d [0:ROWS-1]);
    logic [15:0] v;
    for (int i = 0; i < ROWS; i++) v[i] = d[i];
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic int eff_gap(input int pipes);
    int e;
`ifdef COLPAT_DIFFICULTY_EN
    e = GAP - pipes / 4;
    if (e < 2) e = 2;
`else
    e = GAP;
`endif
    return e;
  endfunction

  function automatic int clamp_top(input int r, input int eff);
    int mx;
    mx = ROWS - eff - 1;
    if (r < 1) return 1;
    if (r > mx) return mx;
    return r;
  endfunction

  int         m_prime = 0;   // edges seen since (re)start, saturating at 2
  int         m_k = 0;       // columns accepted since stream opened
  logic [7:0] m_lfsr = 8'hA5;
  int         m_gap = 0;
  int         m_pipes = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset || restart) begin
      m_prime = 0; m_k = 0; m_lfsr = 8'hA5; m_gap = 0; m_pipes = 0;
    end else if (!freeze) begin
      if (m_prime < 2) begin
        m_prime++;
        m_k = 0;
      end else if (col_ready) begin
        if (m_k % PERIOD == SPACING - 1) m_gap = clamp_top(int'(m_lfsr[3:0]), eff_gap(m_pipes));
        if (m_k % PERIOD == PERIOD - 1 && m_pipes < 15) m_pipes++;
        m_lfsr = lfsr_next(m_lfsr);
        m_k++;
      end
    end
  end

  function automatic logic [15:0] exp_data();
    logic [15:0] v;
    bit pipe;
    pipe = (m_prime == 2) && (m_k % PERIOD >= SPACING);
    for (int i = 0; i < ROWS; i++)
      v[i] = pipe && !(i >= m_gap && i < m_gap + eff_gap(m_pipes));
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_valid", int'(col_valid), int'((m_prime == 2) && !freeze));
      chk("model_is_pipe", int'(is_pipe), int'((m_prime == 2) && (m_k % PERIOD >= SPACING)));
      chk("model_gap_top", int'(gap_top), m_gap);
      chk("model_data", int'(pack(output_data)), int'(exp_data()));
`ifdef COLPAT_DIFFICULTY_EN
      chk("model_difficulty", int'(difficulty), m_pipes / 4);
`endif
    end
  end

  // ---------------- SEED=0 instance: clamp range over 64 pipes ----------------
  int pipes2 = 0;
  bit prev_pipe2 = 1'b0;
  bit done2 = 1'b0;

  always @(negedge clk) begin
    if (reset2 && !done2) begin
      if (pipe2 && !prev_pipe2) begin
        int zeros;
        pipes2++;
        zeros = 0;
        for (int i = 0; i < ROWS; i++) if (!data2[i]) zeros++;
`ifdef COLPAT_DIFFICULTY_EN
        chk("seed0_gap_range", int'(gap2 >= 1 && gap2 <= 13), 1);
        if (pipes2 == 9) chk("seed0_gap_is_2", zeros, 2);
        if (pipes2 == 64) chk("seed0_difficulty_sat", int'(diff2), 3);
`else
        chk("seed0_gap_range", int'(gap2 >= 1 && gap2 <= 11), 1);
        chk("seed0_gap_width", zeros, GAP);
`endif
        if (pipes2 == 1) chk("seed0_first_gap", int'(gap2), 8);
        if (pipes2 == 64) done2 = 1'b1;
      end
      prev_pipe2 = pipe2;
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [63:0] rp;
    logic [63:0] fp;
    int budget;
    rp = 64'hF3A5_0FFE_C96D_7B11;
    fp = 64'h0000_0F00_0030_0000;

    step(2);
    chk("reset_valid", int'(col_valid), 0);
    chk("reset_is_pipe", int'(is_pipe), 0);
    chk("reset_gap_top", int'(gap_top), 0);
    chk("reset_data", int'(pack(output_data)), 0);
    chk_en = 1'b1;

    col_ready = 1'b1; reset = 1'b1; reset2 = 1'b1;
    step(1);
    chk("prime_edge1_valid", int'(col_valid), 0);
    step(1);
    chk("first_col_valid", int'(col_valid), 1);
    chk("first_col_blank", int'(pack(output_data)), 0);
    step(4);
    chk("pipe1_is_pipe", int'(is_pipe), 1);
    chk("pipe1_gap_top", int'(gap_top), 10);
    chk("pipe1_data", int'(pack(output_data)), 16'hC3FF);

    col_ready = 1'b0;
    step(5);
    chk("stall_gap_top", int'(gap_top), 10);
    chk("stall_data", int'(pack(output_data)), 16'hC3FF);
    chk("stall_valid", int'(col_valid), 1);
    col_ready = 1'b1;
    step(1);
    chk("pipe1_col2_is_pipe", int'(is_pipe), 1);
    chk("pipe1_col2_gap_top", int'(gap_top), 10);
    step(1);
    chk("after_pipe_blank", int'(is_pipe), 0);

    freeze = 1'b1;
    #1 chk("freeze_valid_low", int'(col_valid), 0);
    step(3);
    chk("freeze_held_blank", int'(is_pipe), 0);
    freeze = 1'b0;
    #1 chk("freeze_release_valid", int'(col_valid), 1);
    step(4);
    chk("pipe2_gap_clamped", int'(gap_top), 11);
    chk("pipe2_data", int'(pack(output_data)), 16'h87FF);

    restart = 1'b1;
    step(1);
    restart = 1'b0;
    chk("restart_valid", int'(col_valid), 0);
    chk("restart_gap_top", int'(gap_top), 0);
    step(1);
    chk("restart_prime_valid", int'(col_valid), 0);
    step(1);
    chk("restart_first_valid", int'(col_valid), 1);
    step(4);
    chk("restart_pipe_gap_top", int'(gap_top), 10);
    chk("restart_pipe_data", int'(pack(output_data)), 16'hC3FF);

    reset = 1'b0;
    #1;
    chk("async_reset_valid", int'(col_valid), 0);
    chk("async_reset_is_pipe", int'(is_pipe), 0);
    chk("async_reset_data", int'(pack(output_data)), 0);
    step(1);
    reset = 1'b1;
    step(2);

    for (int i = 0; i < 64; i++) begin
      col_ready = rp[i];
      freeze = fp[i];
      step(1);
    end
    freeze = 1'b0;
    col_ready = 1'b1;

    budget = 0;
    while (!done2 && budget < 2000) begin
      step(1);
      budget++;
    end
    chk("seed0_done", int'(done2), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
